// File: rtl/led_run_ctrl_if.sv
// Board-side signal bundle for the LED running-light controller:
// raw buttons and switches in, shifter controls and status out.
interface led_run_ctrl_if #(
    parameter int WIDTH = 18
);
    localparam int POS_W = $clog2(WIDTH);

    logic             btn_pause_n;
    logic             btn_step_n;
    logic [1:0]       sw_speed;
    logic             sw_dir;
    logic             sw_bounce;
    logic             load;
    logic             step;
    logic             step_dir;
    logic [1:0]       state;
    logic [POS_W-1:0] pos;

    modport master (
        output btn_pause_n, btn_step_n, sw_speed, sw_dir, sw_bounce,
        input  load, step, step_dir, state, pos
    );

    modport slave (
        input  btn_pause_n, btn_step_n, sw_speed, sw_dir, sw_bounce,
        output load, step, step_dir, state, pos
    );
endinterface

// File: rtl/led_run_ctrl.sv
// RUN/PAUSE sequencer for the LED shifter: button debounce, rate prescaler,
// and lit-position tracking with wrap or ping-pong direction.
module led_run_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WIDTH           = 18
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    led_run_ctrl_if.slave bus
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(CLK_HZ);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] period_term(input logic [1:0] speed);
        case (speed)
            2'd0:    return CNT_W'(CLK_HZ - 1);
            2'd1:    return CNT_W'(CLK_HZ / 2 - 1);
            2'd2:    return CNT_W'(CLK_HZ / 5 - 1);
            default: return CNT_W'(CLK_HZ / 10 - 1);
        endcase
    endfunction

    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p, input logic dir);
        if (dir)
            return (p == '0) ? POS_LAST : p - 1'b1;
        else
            return (p == POS_LAST) ? '0 : p + 1'b1;
    endfunction

    // Button path: bit 0 = pause, bit 1 = step
    logic [1:0]      btn_raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      db_lvl;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign btn_raw = {bus.btn_step_n, bus.btn_pause_n};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_p0   <= '1;
            sync_p1   <= '1;
            db_lvl    <= '1;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= sync_p1[i];
                    press[i]  <= ~sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic pause_ev;
    logic step_ev;

    // A coincident pause press swallows the step press
    assign pause_ev = press[0];
    assign step_ev  = press[1] & ~press[0];

    // Sequencer state
    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_q;
    logic             load_nxt;
    logic             step_q;
    logic             step_nxt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state_q <= S_INIT;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_INIT:  state_nxt = S_RUN;
            S_RUN:   if (pause_ev) state_nxt = S_PAUSE;
            S_PAUSE: if (pause_ev) state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    // Count at or past the selected terminal is treated as terminal, so a
    // speed change never stretches the current period.
    always_comb begin
        load_nxt = 1'b0;
        step_nxt = 1'b0;
        cnt_nxt  = cnt_q;
        case (state_q)
            S_INIT: begin
                load_nxt = 1'b1;
                cnt_nxt  = '0;
            end
            S_RUN: begin
                if (!pause_ev) begin
                    if (cnt_q >= period_term(bus.sw_speed)) begin
                        step_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            S_PAUSE: step_nxt = step_ev;
            default: ;
        endcase
    end

    // Position and direction
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_step;
    logic             dir_q;
    logic             dir_use;
    logic             bnc_q;

    // Bounce mode always moves inward from either end, regardless of bnc_q
    always_comb begin
        dir_use = bus.sw_dir;
        if (bus.sw_bounce) begin
            if (pos_q == POS_LAST)
                dir_use = 1'b1;
            else if (pos_q == '0)
                dir_use = 1'b0;
            else
                dir_use = bnc_q;
        end
        pos_step = next_pos(pos_q, dir_use);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
            step_q <= 1'b0;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            bnc_q  <= 1'b0;
        end else begin
            load_q <= load_nxt;
            step_q <= step_nxt;
            cnt_q  <= cnt_nxt;
            if (load_nxt) begin
                pos_q <= '0;
            end else if (step_nxt) begin
                pos_q <= pos_step;
                dir_q <= dir_use;
            end
            if (!bus.sw_bounce)
                bnc_q <= bus.sw_dir;
            else if (step_nxt && pos_step == POS_LAST)
                bnc_q <= 1'b1;
            else if (step_nxt && pos_step == '0)
                bnc_q <= 1'b0;
        end
    end

    assign bus.load     = load_q;
    assign bus.step     = step_q;
    assign bus.step_dir = dir_q;
    assign bus.state    = state_q;
    assign bus.pos      = pos_q;
endmodule

// File: tb/tb_led_run_ctrl.sv
// Scenario bench for led_run_ctrl with a step scoreboard (cycle, pos, dir).
module tb_led_run_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   t0     = 0;

    typedef struct {
        int         cyc;
        logic [2:0] pos;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    led_run_ctrl_if #(.WIDTH(6)) bus ();

    led_run_ctrl #(
        .CLK_HZ(100),
        .DEBOUNCE_CYCLES(4),
        .WIDTH(6)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_step(input int c, input int p, input logic d);
        exp_t x;
        x.cyc = c;
        x.pos = 3'(p);
        x.dir = d;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.load, bus.step, bus.step_dir} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got load/step/dir=%b, required 000", {bus.load, bus.step, bus.step_dir});
        end
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, required 0", bus.state);
        end
        checks++;
        if (bus.pos !== 3'd0) begin
            errors++;
            $display("FAIL reset_pos: got %0d, required 0", bus.pos);
        end
        reset = 1'b0;
        @(negedge clk);
        t0 = cyc;
        checks++;
        if (bus.load !== 1'b1 || bus.step !== 1'b0 || bus.state !== 2'd1 || bus.pos !== 3'd0) begin
            errors++;
            $display("FAIL first_load: got load=%b step=%b state=%0d pos=%0d, required 1 0 1 0", bus.load, bus.step, bus.state, bus.pos);
        end
        @(negedge clk);
        checks++;
        if (bus.load !== 1'b0) begin
            errors++;
            $display("FAIL load_width: got load=%b one cycle later, required 0", bus.load);
        end
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 6; k++) expect_step(t0 + 10 * k, k % 6, 1'b0);
        while (cyc < t0 + 60) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL free_run_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir || bus.load !== 1'b0) begin
                        errors++;
                        $display("FAIL free_run_step: got cycle=%0d pos=%0d dir=%b load=%b, required cycle=%0d pos=%0d dir=%b load=0", cyc, bus.pos, bus.step_dir, bus.load, e.cyc, e.pos, e.dir);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL free_run_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pause_glitch();
        int s;
        s = cyc;
        bus.btn_pause_n = 1'b0;
        expect_step(s + 10, 1, 1'b0);
        while (cyc < s + 10) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL glitch_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL glitch_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
            if (cyc == s + 3) bus.btn_pause_n = 1'b1;
        end
        checks++;
        if (bus.state !== 2'd1) begin
            errors++;
            $display("FAIL glitch_state: got %0d, required 1", bus.state);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pause_resume();
        int s;
        s = cyc;
        bus.btn_pause_n = 1'b0;
        // paused with 6 counts held; resume at s+27 leaves 4 to go
        expect_step(s + 31, 2, 1'b0);
        expect_step(s + 41, 3, 1'b0);
        while (cyc < s + 41) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pause_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL pause_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
            if (cyc == s + 6 || cyc == s + 7 || cyc == s + 27) begin
                checks++;
                if (bus.state !== ((cyc == s + 7) ? 2'd2 : 2'd1)) begin
                    errors++;
                    $display("FAIL pause_state: got %0d at cycle offset %0d, required %0d", bus.state, cyc - s, (cyc == s + 7) ? 2 : 1);
                end
            end
            if (cyc == s + 8 || cyc == s + 27) bus.btn_pause_n = 1'b1;
            if (cyc == s + 20) bus.btn_pause_n = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pause_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_single_step();
        int s;
        s = cyc;
        bus.btn_pause_n = 1'b0;
        expect_step(s + 21, 4, 1'b0);
        expect_step(s + 41, 5, 1'b0);
        while (cyc < s + 41) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL single_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL single_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
            if (cyc == s + 7 || cyc == s + 25 || cyc == s + 37) begin
                checks++;
                if (bus.state !== ((cyc == s + 37) ? 2'd1 : 2'd2)) begin
                    errors++;
                    $display("FAIL single_state: got %0d at cycle offset %0d, required %0d", bus.state, cyc - s, (cyc == s + 37) ? 1 : 2);
                end
            end
            if (cyc == s + 6) bus.btn_pause_n = 1'b1;
            if (cyc == s + 14) bus.btn_step_n = 1'b0;
            if (cyc == s + 20) bus.btn_step_n = 1'b1;
            if (cyc == s + 30) begin
                bus.btn_pause_n = 1'b0;
                bus.btn_step_n  = 1'b0;
            end
            if (cyc == s + 36) begin
                bus.btn_pause_n = 1'b1;
                bus.btn_step_n  = 1'b1;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int s;
        int bp[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        s = cyc;
        expect_step(s + 10, 0, 1'b0);
        for (int k = 0; k < 11; k++) expect_step(s + 20 + 10 * k, bp[k], (k >= 5 && k <= 9) ? 1'b1 : 1'b0);
        while (cyc < s + 120) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bounce_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL bounce_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
            if (cyc == s + 10) bus.sw_bounce = 1'b1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_wrap_right();
        int s;
        s = cyc;
        bus.sw_bounce = 1'b0;
        bus.sw_dir    = 1'b1;
        expect_step(s + 10, 0, 1'b1);
        expect_step(s + 20, 5, 1'b1);
        expect_step(s + 30, 4, 1'b1);
        while (cyc < s + 30) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL wrap_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_speed_change();
        int s;
        s = cyc;
        bus.sw_speed = 2'd0;
        expect_step(s + 51, 3, 1'b1);
        expect_step(s + 61, 2, 1'b1);
        expect_step(s + 71, 1, 1'b1);
        while (cyc < s + 71) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL speed_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL speed_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
            if (cyc == s + 50) bus.sw_speed = 2'd3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL speed_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset();
        int s;
        s = cyc;
        while (cyc < s + 5) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL midreset_pre: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
            end
            if (cyc == s + 1) bus.btn_pause_n = 1'b0;
        end
        reset = 1'b1;
        bus.btn_pause_n = 1'b1;
        #1;
        checks++;
        if ({bus.load, bus.step, bus.step_dir, bus.state, bus.pos} !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: got load=%b step=%b dir=%b state=%0d pos=%0d, required all 0", bus.load, bus.step, bus.step_dir, bus.state, bus.pos);
        end
        @(negedge clk);
        checks++;
        if ({bus.load, bus.step, bus.step_dir, bus.state, bus.pos} !== 8'd0) begin
            errors++;
            $display("FAIL midreset_held: got load=%b step=%b dir=%b state=%0d pos=%0d, required all 0", bus.load, bus.step, bus.step_dir, bus.state, bus.pos);
        end
        reset = 1'b0;
        @(negedge clk);
        s = cyc;
        checks++;
        if (bus.load !== 1'b1 || bus.state !== 2'd1 || bus.pos !== 3'd0) begin
            errors++;
            $display("FAIL midreset_load: got load=%b state=%0d pos=%0d, required 1 1 0", bus.load, bus.state, bus.pos);
        end
        expect_step(s + 10, 5, 1'b1);
        expect_step(s + 20, 4, 1'b1);
        while (cyc < s + 20) begin
            @(negedge clk);
            if (bus.step !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_step: unexpected step at cycle %0d pos=%0d, required none", cyc, bus.pos);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.pos !== e.pos || bus.step_dir !== e.dir) begin
                        errors++;
                        $display("FAIL midreset_step: got cycle=%0d pos=%0d dir=%b, required cycle=%0d pos=%0d dir=%b", cyc, bus.pos, bus.step_dir, e.cyc, e.pos, e.dir);
                    end
                end
            end
        end
        checks++;
        if (bus.state !== 2'd1) begin
            errors++;
            $display("FAIL midreset_state: got %0d, required 1", bus.state);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_missing: got %0d steps outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.btn_pause_n = 1'b1;
        bus.btn_step_n  = 1'b1;
        bus.sw_speed    = 2'd3;
        bus.sw_dir      = 1'b0;
        bus.sw_bounce   = 1'b0;
        test_reset();
        test_free_run();
        test_pause_glitch();
        test_pause_resume();
        test_single_step();
        test_bounce();
        test_wrap_right();
        test_speed_change();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_run_ctrl.md
# led_run_ctrl

Sequencing controller for the LED running-light shifter. It debounces the pause and step push buttons and runs the RUN/PAUSE state machine. It generates single-cycle step strobes at a switch-selected rate and tracks the lit-LED position. Its direction output supports both wrap-around rotation and ping-pong bounce. It sits between the board inputs (KEY/SW) and the LEDR shift register, which only has to obey `load`, `step` and `step_dir`.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz; the rate table derives from it.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a button level (20 ms at 50 MHz).
- `WIDTH`, 18, number of LEDs in the chain, ≥2.
- `CLOCK_50` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `btn_pause_n` input 1: raw pause button, active-low, asynchronous to the clock.
- `btn_step_n` input 1: raw single-step button, active-low, asynchronous to the clock.
- `sw_speed` input 2: rate select. 0=1 Hz, 1=2 Hz, 2=5 Hz, 3=10 Hz.
- `sw_dir` input 1: 0=left (pos increments), 1=right (pos decrements).
- `sw_bounce` input 1: 1=ping-pong mode, 0=wrap mode.
- `load` output 1: one-cycle pulse; the shifter loads the single-bit pattern at bit 0.
- `step` output 1: one-cycle pulse; the shifter moves one position.
- `step_dir` output 1: direction for the current `step`, valid whenever `step`=1.
- `state` output 2: 0=INIT, 1=RUN, 2=PAUSE.
- `pos` output clog2(WIDTH): index of the lit LED.

## Operation
- **Button input path**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse on a debounced 1→0 transition. Releasing a button produces no event.
- **FSM**
  - INIT: unconditionally goes to RUN on the next edge. On that edge `load`=1 and `pos`=0.
  - RUN: the prescaler counts. A pause event goes to PAUSE. Step events are ignored.
  - PAUSE: the prescaler holds its value. A pause event goes to RUN and counting resumes from the held value. A step event issues exactly one `step`; the prescaler is not touched.
  - If pause and step events fall in the same cycle, pause wins and the step event is discarded.
- **Prescaler**
  - The period is P = CLK_HZ/rate, with rate from `sw_speed`; the count runs 0..P-1.
  - At count == P-1 in RUN: `step`=1 and the count returns to 0.
  - Speed change: if the current count ≥ new P-1, treat it as terminal. Issue `step` next cycle and clear the count. The period never overruns.
- **Position and direction**
  - Wrap mode: `step_dir`=`sw_dir`.
    - Left: `pos` ← (pos+1) mod WIDTH.
    - Right: `pos` ← (pos-1) mod WIDTH.
  - Bounce mode: `step_dir` comes from an internal bounce register.
    - While `sw_bounce`=0, the bounce register tracks `sw_dir` every cycle.
    - When a step lands on pos WIDTH-1, the register becomes 1 (right). When a step lands on pos 0, it becomes 0 (left).
    - `sw_dir` is ignored while `sw_bounce`=1.
    - No wrap ever occurs in bounce mode. Steps at the ends always move inward.
  - `pos` changes only on the edge where `step`=1, or to 0 on `load`.

## Timing
- **Reset values:** `state`=INIT, `load`=0, `step`=0, `step_dir`=0, `pos`=0, prescaler=0, debounced levels=1 (released), bounce register=0.
- **Registered outputs:** all outputs are registered. `step_dir` and `pos` update on the same edge that asserts `step`, and `pos` reflects the post-step index.
- **Button latency:** from a raw edge to the press event is 2 (sync) + `DEBOUNCE_CYCLES` cycles. The FSM reacts on the following edge.
- **Step spacing in RUN:** consecutive `step` pulses are exactly P cycles apart. The first `step` after `load` comes P cycles later.
- **`load` and `step`:** never high in the same cycle.
- **Reset mid-operation:** all state returns to reset values immediately, with no pending step or press event retained. `load` fires again on the first edge after release.

## Test plan
Bench parameters: CLK_HZ=100, DEBOUNCE_CYCLES=4, WIDTH=6.
- **Reset release, free run:** release `reset`, `sw_speed`=3. Expect `load` at edge 1, `state`=RUN, then `step` every 10 cycles with `pos` 1,2,…,5,0.
- **Bounce and glitch rejection:** pulse `btn_pause_n` low for 3 cycles. Expect no state change. Hold it low for ≥6 cycles and expect `state`=PAUSE and `step` stopping. Press again and expect the next `step` after the remaining held count.
- **Single step:** in PAUSE, a step press gives exactly one `step` and `pos` +1. Pause and step presses on the same cycle give `state`=RUN and no `step`.
- **Bounce mode:** `sw_bounce`=1 from `pos`=0 gives the `pos` sequence 1,2,3,4,5,4,3,2,1,0,1, with `step_dir` 1 exactly on the descending steps.
- **Wrap right:** `sw_dir`=1, `sw_bounce`=0, from `pos`=0 gives `pos` 5,4,…; separately, `sw_speed` 0→3 at count 50 gives `step` on the next cycle, then steps every 10 cycles.
- **Mid-run reset:** assert `reset` for 1 cycle mid-run. Expect all outputs at reset values while asserted, then `load` again on the first edge after release.
